// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux-select arbiter.
// MAX_HOLD is only consumed when MUX_ARB_HOLD_TIMEOUT_EN is defined.
package mux_arb_pkg;

  localparam int NUM_REQ  = 4;
  localparam int SEL_W    = 2;
  localparam int MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    return NUM_REQ'(1) << s;
  endfunction

endpackage

// File: rtl/mux_sel_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;
  logic             found;

  assign any = |req;

  // SEL_W-bit addition wraps 3->0 for free.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select, one-hot grant and valid/ready qualification.
// Optional burst timeout enabled by defining MUX_ARB_HOLD_TIMEOUT_EN.
module mux_sel_rr_arbiter
  import mux_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] grant,
  output logic               out_valid,
  output logic               busy
);

  arb_state_t         state, state_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt, sel_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               beat;
  logic               hold_hit;
  logic               release_now;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign busy      = (state == GRANT);
  assign out_valid = busy && req[sel];
  assign beat      = out_valid && out_ready;

`ifdef MUX_ARB_HOLD_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  assign hold_hit = beat && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt <= '0;
    else     hold_cnt <= hold_nxt;
  end

  always_comb begin
    hold_nxt = hold_cnt;
    if (state == IDLE) begin
      hold_nxt = '0;
    end else if (beat && !release_now && (hold_cnt != {HOLD_W{1'b1}})) begin
      hold_nxt = hold_cnt + HOLD_W'(1);
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  // A dropped request and a timeout in the same cycle collapse into one release.
  assign release_now = !req[sel] || hold_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          sel_nxt   = pick_idx;
          grant_nxt = sel_onehot(pick_idx);
        end
      end
      GRANT: begin
        // sel is frozen for the whole burst; only release touches ptr/grant.
        if (release_now) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = sel + SEL_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Self-checking bench for mux_sel_rr_arbiter: directed scenarios plus random traffic vs a behavioural model.
module tb_mux_sel_rr_arbiter;

  localparam int TB_MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       out_valid;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model: who owns the mux, where the scan starts, beats in the burst
  bit m_granted;
  int m_owner;
  int m_ptr;
  int m_beats;

  mux_sel_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_granted = 1'b0;
    m_owner   = 0;
    m_ptr     = 0;
    m_beats   = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic rdy);
    bit found;
    bit beat;
    bit rel;
    if (!m_granted) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!found && r[(m_ptr + k) % 4]) begin
          found     = 1'b1;
          m_owner   = (m_ptr + k) % 4;
          m_granted = 1'b1;
          m_beats   = 0;
        end
      end
    end else begin
      beat = r[m_owner] && rdy;
      rel  = !r[m_owner];
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
      if (beat && m_beats == TB_MAX_HOLD - 1) rel = 1'b1;
`endif
      if (rel) begin
        m_granted = 1'b0;
        m_ptr     = (m_owner + 1) % 4;
      end else if (beat) begin
        m_beats++;
      end
    end
  endtask

  // Called at a falling edge: drive, check combinational outputs, take one rising edge, check registers.
  task automatic cycle(input logic [3:0] r, input logic rdy, input string tag);
    logic [3:0] g_exp;
    req       = r;
    out_ready = rdy;
    #1;
    check({tag, "/out_valid"}, 8'(out_valid), 8'(m_granted && r[m_owner]));
    check({tag, "/busy_pre"}, 8'(busy), 8'(m_granted));
    model_edge(r, rdy);
    @(posedge clk);
    #1;
    g_exp = m_granted ? 4'(1 << m_owner) : 4'd0;
    check({tag, "/sel"}, 8'(sel), 8'(m_owner));
    check({tag, "/grant"}, 8'(grant), 8'(g_exp));
    check({tag, "/busy"}, 8'(busy), 8'(m_granted));
    @(negedge clk);
  endtask

  // Asserted away from any clock edge so the asynchronous path is what is observed.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "/rst_sel"}, 8'(sel), 8'h0);
    check({tag, "/rst_grant"}, 8'(grant), 8'h0);
    check({tag, "/rst_valid"}, 8'(out_valid), 8'h0);
    check({tag, "/rst_busy"}, 8'(busy), 8'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] prev_grant;
    logic [3:0] r;
    logic [1:0] stall_sel;

    rst       = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("por/sel", 8'(sel), 8'h0);
    check("por/busy", 8'(busy), 8'h0);

    // reset mid-burst with sel=2
    cycle(4'b0100, 1'b1, "t1_grant");
    cycle(4'b0100, 1'b1, "t1_beat");
    check("t1/sel_before_rst", 8'(sel), 8'h2);
    do_reset("t1");

    // single requester, then drop
    cycle(4'b0100, 1'b1, "t2_req");
    check("t2/sel", 8'(sel), 8'h2);
    check("t2/grant", 8'(grant), 8'h4);
    cycle(4'b0100, 1'b1, "t2_hold");
    cycle(4'b0000, 1'b1, "t2_drop");
    check("t2/idle", 8'(busy), 8'h0);

    // ptr=3 now: 3 wins first, then wrap to 0
    cycle(4'b1001, 1'b1, "t4_first");
    check("t4/first_sel", 8'(sel), 8'h3);
    cycle(4'b1001, 1'b1, "t4_beat");
    cycle(4'b0001, 1'b1, "t4_drop3");
    check("t4/bubble", 8'(busy), 8'h0);
    cycle(4'b0001, 1'b1, "t4_second");
    check("t4/second_sel", 8'(sel), 8'h0);
    cycle(4'b0000, 1'b1, "t4_drop0");

    // fairness: all request, each owner drops after 2 beats
    do_reset("t3");
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      r = (m_granted && m_beats == 2) ? (4'b1111 & ~4'(1 << m_owner)) : 4'b1111;
      prev_grant = grant;
      cycle(r, 1'b1, "t3");
      if (prev_grant == 4'd0 && grant != 4'd0) order.push_back(int'(sel));
    end
    check("t3/grant_count", 8'(order.size()), 8'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) check("t3/order", 8'(order[i]), 8'(exp_order[i]));
    end
    cycle(4'b0000, 1'b1, "t3_end");

    // stall mid-burst
    do_reset("t5");
    cycle(4'b0010, 1'b1, "t5_grant");
    stall_sel = sel;
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0010, 1'b0, "t5_stall");
      check("t5/sel_stable", 8'(sel), 8'(stall_sel));
      check("t5/valid", 8'(out_valid), 8'h1);
    end
`ifndef MUX_ARB_HOLD_TIMEOUT_EN
    for (int i = 0; i < 12; i++) cycle(4'b0010, 1'b1, "t5_long");
    check("t5/no_release", 8'(busy), 8'h1);
`endif
    cycle(4'b0000, 1'b1, "t5_end");

`ifdef MUX_ARB_HOLD_TIMEOUT_EN
    // timeout with 0 and 1 requesting constantly
    begin
      int n0;
      bit saw1;
      n0   = 0;
      saw1 = 1'b0;
      do_reset("t6");
      for (int c = 0; c < 40 && !saw1; c++) begin
        if (busy && sel == 2'd0) n0++;
        cycle(4'b0011, 1'b1, "t6");
        if (busy && sel == 2'd1) saw1 = 1'b1;
      end
      check("t6/beats_src0", 8'(n0), 8'(TB_MAX_HOLD));
      check("t6/src1_granted", 8'(saw1), 8'h1);
      cycle(4'b0000, 1'b1, "t6_end");
    end
`endif

    // random traffic, owner's request biased high for longer bursts
    do_reset("rnd");
    for (int c = 0; c < 400; c++) begin
      r = 4'($urandom_range(0, 15));
      if (m_granted && $urandom_range(0, 3) != 0) r = r | 4'(1 << m_owner);
      cycle(r, $urandom_range(0, 3) != 0, "rnd");
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
